// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the rx pin, validates the start bit, samples mid-bit
// and delivers each byte through a one-entry holding register with avail/overrun flags.
`timescale 1ns/1ps

module uart_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   input  logic [15:0] clk_per_bit,
   input  logic        rx_read,
   output logic [7:0]  rx_data,
   output logic        rx_avail,
   output logic        rx_valid,
   output logic        frame_err,
   output logic        overrun,
   output logic        rx_busy
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      RECOVER
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [15:0]            cnt_q, cnt_d;
   logic [15:0]            div_q, div_d;
   logic [2:0]             bit_q, bit_d;
   logic [7:0]             shift_q, shift_d;
   logic [7:0]             rx_data_q, rx_data_d;
   logic                   rx_avail_q, rx_avail_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overrun_q, overrun_d;

   logic        rx_s;
   logic        byte_done;
   logic [15:0] half_m1;
   logic [15:0] div_m1;

   assign rx_s    = sync_q[SYNC_STAGES-1];
   assign half_m1 = (div_q >> 1) - 16'd1;
   assign div_m1  = div_q - 16'd1;

   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], rx};
      state_d     = state_q;
      cnt_d       = cnt_q;
      div_d       = div_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_avail_d  = rx_avail_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = overrun_q;
      byte_done   = 1'b0;

      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = 16'd0;
               div_d   = clk_per_bit;
            end
         end
         START: begin
            // A start bit that is high again at its midpoint is treated as noise
            if (cnt_q == half_m1) begin
               cnt_d = 16'd0;
               bit_d = 3'd0;
               state_d = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         DATA: begin
            if (cnt_q == div_m1) begin
               cnt_d          = 16'd0;
               shift_d[bit_q] = rx_s;
               bit_d          = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         STOP: begin
            if (cnt_q == div_m1) begin
               cnt_d = 16'd0;
               if (rx_s) begin
                  byte_done = 1'b1;
                  state_d   = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = RECOVER;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RECOVER: begin
            // Hold off until the line returns high so a break is never seen as a start bit
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (rx_read && rx_avail_q) begin
         rx_avail_d = 1'b0;
         overrun_d  = 1'b0;
      end
      // A simultaneous acknowledge consumes the old byte, so only an unread one overruns
      if (byte_done) begin
         rx_data_d  = shift_q;
         rx_valid_d = 1'b1;
         rx_avail_d = 1'b1;
         if (rx_avail_q && !rx_read) begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         sync_q      <= '1;
         cnt_q       <= 16'd0;
         div_q       <= 16'd0;
         bit_q       <= 3'd0;
         shift_q     <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_avail_q  <= 1'b0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_avail_q  <= rx_avail_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_avail  = rx_avail_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a serial-line driver pushes expected bytes to a
// scoreboard queue and a negedge monitor pops and compares them on every rx_valid.
`timescale 1ns/1ps

module tb_uart_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx;
   logic [15:0] clk_per_bit;
   logic        rx_read;
   logic [7:0]  rx_data;
   logic        rx_avail;
   logic        rx_valid;
   logic        frame_err;
   logic        overrun;
   logic        rx_busy;

   int          checks = 0;
   int          failures = 0;
   int          valid_count = 0;
   int          ferr_count = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  exp_b;
   time         last_valid_time = 0;
   time         frame_start_time = 0;

   uart_rx #(.SYNC_STAGES(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx),
      .clk_per_bit (clk_per_bit),
      .rx_read     (rx_read),
      .rx_data     (rx_data),
      .rx_avail    (rx_avail),
      .rx_valid    (rx_valid),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .rx_busy     (rx_busy)
   );

   always #5 clk = ~clk;

   // Scoreboard side: every delivered byte must match the oldest outstanding one
   always @(negedge clk) begin
      if (!reset) begin
         if (rx_valid) begin
            valid_count++;
            last_valid_time = $time;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("[TB] FAIL unexpected_byte: got rx_data=%02h, expected no delivery", rx_data);
            end else begin
               exp_b = exp_q.pop_front();
               if (rx_data !== exp_b) begin
                  failures++;
                  $display("[TB] FAIL scoreboard_byte: got %02h, expected %02h", rx_data, exp_b);
               end
            end
         end
         if (frame_err) ferr_count++;
      end
   end

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic send_frame(input logic [7:0] b, input logic stop_val, input int cpb, input bit push);
      @(posedge clk); #1;
      if (push) exp_q.push_back(b);
      rx = 1'b0;
      frame_start_time = $time;
      repeat (cpb) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (cpb) @(posedge clk);
         #1;
      end
      rx = stop_val;
      repeat (cpb) @(posedge clk);
      #1;
   endtask

   task automatic read_pulse();
      @(negedge clk); rx_read = 1'b1;
      @(negedge clk); rx_read = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; rx = 1'b1; rx_read = 1'b0; clk_per_bit = 16'd16;
      repeat (3) @(negedge clk);
      checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_rx_data: got %02h expected 00", rx_data); end
      checks++; if (rx_avail !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_avail: got %b expected 0", rx_avail); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
      checks++; if (rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_busy: got %b expected 0", rx_busy); end
      @(negedge clk); reset = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_after_reset: got busy=%b expected 0", rx_busy); end
   endtask

   task automatic test_basic();
      int v0, f0, lat;
      v0 = valid_count; f0 = ferr_count;
      send_frame(8'hA5, 1'b1, 16, 1'b1);
      repeat (24) @(negedge clk);
      lat = int'((last_valid_time - frame_start_time) / 10);
      checks++; if (valid_count - v0 !== 1) begin failures++; $display("[TB] FAIL basic_valid_pulses: got %0d expected 1", valid_count - v0); end
      checks++; if (lat < 152 || lat > 156) begin failures++; $display("[TB] FAIL basic_latency: got %0d cycles expected 154+/-2", lat); end
      checks++; if (rx_data !== 8'hA5) begin failures++; $display("[TB] FAIL basic_rx_data: got %02h expected a5", rx_data); end
      checks++; if (rx_avail !== 1'b1) begin failures++; $display("[TB] FAIL basic_rx_avail: got %b expected 1", rx_avail); end
      checks++; if (ferr_count !== f0) begin failures++; $display("[TB] FAIL basic_frame_err: got %0d pulses expected 0", ferr_count - f0); end
   endtask

   task automatic test_glitch();
      int v0, f0, guard;
      v0 = valid_count; f0 = ferr_count;
      @(posedge clk); #1 rx = 1'b0;
      repeat (4) @(posedge clk);
      #1 rx = 1'b1;
      @(negedge clk);
      checks++; if (rx_busy !== 1'b1) begin failures++; $display("[TB] FAIL glitch_busy_start: got %b expected 1", rx_busy); end
      guard = 0;
      while (rx_busy && guard < 40) begin @(negedge clk); guard++; end
      checks++; if (rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL glitch_busy_release: got %b expected 0 within 40 cycles", rx_busy); end
      repeat (40) @(negedge clk);
      checks++; if (valid_count !== v0) begin failures++; $display("[TB] FAIL glitch_no_valid: got %0d pulses expected 0", valid_count - v0); end
      checks++; if (ferr_count !== f0) begin failures++; $display("[TB] FAIL glitch_no_frame_err: got %0d pulses expected 0", ferr_count - f0); end
   endtask

   task automatic test_frame_error();
      int v0, f0;
      logic       avail_before;
      logic [7:0] data_before;
      v0 = valid_count; f0 = ferr_count;
      avail_before = rx_avail; data_before = rx_data;
      send_frame(8'h3C, 1'b0, 16, 1'b0);
      repeat (40) @(negedge clk);
      checks++; if (ferr_count - f0 !== 1) begin failures++; $display("[TB] FAIL ferr_pulse: got %0d cycles expected 1", ferr_count - f0); end
      checks++; if (valid_count !== v0) begin failures++; $display("[TB] FAIL ferr_no_valid: got %0d pulses expected 0", valid_count - v0); end
      checks++; if (rx_avail !== avail_before) begin failures++; $display("[TB] FAIL ferr_avail_kept: got %b expected %b", rx_avail, avail_before); end
      checks++; if (rx_data !== data_before) begin failures++; $display("[TB] FAIL ferr_data_kept: got %02h expected %02h", rx_data, data_before); end
      checks++; if (rx_busy !== 1'b1) begin failures++; $display("[TB] FAIL ferr_recover_busy: got %b expected 1", rx_busy); end
      rx = 1'b1;
      repeat (6) @(negedge clk);
      checks++; if (rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL ferr_recover_exit: got %b expected 0", rx_busy); end
      read_pulse();
      send_frame(8'h55, 1'b1, 16, 1'b1);
      repeat (24) @(negedge clk);
      checks++; if (rx_data !== 8'h55) begin failures++; $display("[TB] FAIL ferr_next_byte: got %02h expected 55", rx_data); end
      checks++; if (valid_count - v0 !== 1) begin failures++; $display("[TB] FAIL ferr_next_valid: got %0d pulses expected 1", valid_count - v0); end
   endtask

   task automatic test_overrun();
      read_pulse();
      send_frame(8'h11, 1'b1, 16, 1'b1);
      send_frame(8'h22, 1'b1, 16, 1'b1);
      repeat (24) @(negedge clk);
      checks++; if (rx_data !== 8'h22) begin failures++; $display("[TB] FAIL ovr_rx_data: got %02h expected 22", rx_data); end
      checks++; if (rx_avail !== 1'b1) begin failures++; $display("[TB] FAIL ovr_rx_avail: got %b expected 1", rx_avail); end
      checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL ovr_set: got %b expected 1", overrun); end
      read_pulse();
      checks++; if (rx_avail !== 1'b0) begin failures++; $display("[TB] FAIL ovr_read_avail: got %b expected 0", rx_avail); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL ovr_read_clear: got %b expected 0", overrun); end
      read_pulse();
      checks++; if (rx_data !== 8'h22 || rx_avail !== 1'b0) begin failures++; $display("[TB] FAIL ovr_idle_read: got data=%02h avail=%b expected 22/0", rx_data, rx_avail); end
   endtask

   task automatic test_simultaneous_read();
      send_frame(8'h33, 1'b1, 16, 1'b1);
      send_frame(8'h44, 1'b1, 16, 1'b1);
      repeat (24) @(negedge clk);
      checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL sim_setup_overrun: got %b expected 1", overrun); end
      // The acknowledge lands on the stop-bit sample edge, 155 cycles after the start edge
      fork
         send_frame(8'h5A, 1'b1, 16, 1'b1);
         begin
            @(posedge clk); #1;
            repeat (154) @(posedge clk);
            #1 rx_read = 1'b1;
            @(posedge clk);
            #1 rx_read = 1'b0;
         end
      join
      repeat (24) @(negedge clk);
      checks++; if (rx_data !== 8'h5A) begin failures++; $display("[TB] FAIL sim_rx_data: got %02h expected 5a", rx_data); end
      checks++; if (rx_avail !== 1'b1) begin failures++; $display("[TB] FAIL sim_rx_avail: got %b expected 1", rx_avail); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL sim_overrun: got %b expected 0", overrun); end
   endtask

   task automatic test_reset_mid_frame();
      int v0;
      v0 = valid_count;
      fork
         send_frame(8'h96, 1'b1, 16, 1'b0);
         begin
            @(posedge clk); #1;
            repeat (80) @(posedge clk);
            #1 reset = 1'b1;
            @(negedge clk);
            checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL midrst_rx_data: got %02h expected 00", rx_data); end
            checks++; if (rx_avail !== 1'b0 || overrun !== 1'b0) begin failures++; $display("[TB] FAIL midrst_flags: got avail=%b overrun=%b expected 0/0", rx_avail, overrun); end
            checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0 || rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_pulses: got valid=%b ferr=%b busy=%b expected 0/0/0", rx_valid, frame_err, rx_busy); end
            repeat (90) @(posedge clk);
            #1 reset = 1'b0;
         end
      join
      repeat (40) @(negedge clk);
      checks++; if (valid_count !== v0 || rx_avail !== 1'b0 || rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_no_partial: got valids=%0d avail=%b busy=%b expected 0/0/0", valid_count - v0, rx_avail, rx_busy); end
      send_frame(8'hF0, 1'b1, 16, 1'b1);
      repeat (24) @(negedge clk);
      checks++; if (rx_data !== 8'hF0 || rx_avail !== 1'b1) begin failures++; $display("[TB] FAIL midrst_next_byte: got data=%02h avail=%b expected f0/1", rx_data, rx_avail); end
      read_pulse();
   endtask

   task automatic test_divisor_latch();
      int v0;
      v0 = valid_count;
      fork
         send_frame(8'hC3, 1'b1, 16, 1'b1);
         begin
            @(posedge clk); #1;
            repeat (50) @(posedge clk);
            #1 clk_per_bit = 16'd40;
         end
      join
      repeat (24) @(negedge clk);
      clk_per_bit = 16'd16;
      checks++; if (valid_count - v0 !== 1 || rx_data !== 8'hC3) begin failures++; $display("[TB] FAIL latch_divisor: got valids=%0d data=%02h expected 1/c3", valid_count - v0, rx_data); end
      read_pulse();
   endtask

   task automatic test_loopback(input int cpb, input int n);
      int v0, f0, guard;
      clk_per_bit = 16'(cpb);
      repeat (4) @(negedge clk);
      v0 = valid_count; f0 = ferr_count;
      fork
         begin
            for (int i = 0; i < n; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, cpb, 1'b1);
         end
         begin
            for (int i = 0; i < n; i++) begin
               guard = 0;
               @(negedge clk);
               while (!rx_valid && guard < 12 * cpb + 50) begin @(negedge clk); guard++; end
               if (!rx_valid) begin
                  checks++; failures++;
                  $display("[TB] FAIL loopback_timeout: cpb=%0d byte %0d not delivered within %0d cycles", cpb, i, guard);
                  break;
               end
               rx_read = 1'b1;
               @(negedge clk);
               rx_read = 1'b0;
            end
         end
      join
      repeat (8) @(negedge clk);
      checks++; if (valid_count - v0 !== n) begin failures++; $display("[TB] FAIL loopback_count: cpb=%0d got %0d bytes expected %0d", cpb, valid_count - v0, n); end
      checks++; if (ferr_count !== f0 || overrun !== 1'b0) begin failures++; $display("[TB] FAIL loopback_errors: cpb=%0d got ferr=%0d overrun=%b expected 0/0", cpb, ferr_count - f0, overrun); end
      checks++; if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL loopback_drain: cpb=%0d got %0d outstanding expected 0", cpb, exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_simultaneous_read();
      test_reset_mid_frame();
      test_divisor_latch();
      test_loopback(4, 160);
      test_loopback(16, 92);
      test_loopback(868, 4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
